i2c_byte_engine: RTL and testbench

- Byte-level I2C data stage that sits directly upstream of the acknowledge unit.
- Receives 8 bits MSB-first from SDA on SCLK rising edges, or transmits 8 bits MSB-first, changing SDA on SCLK falling edges.
- After the 8th bit it hands the 9th (ack) clock to the ack unit via a one-cycle start pulse, waits for that unit's DONE, then reports byte completion.
- Runs on the system clock and oversamples SCLK/SDA.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_sync_edge.sv | 33 +++
 rtl/i2c_byte_engine.sv | 171 +++++++++++++++++
 tb/tb_i2c_byte_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings and defaults for the I2C byte data stage.
package i2c_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // ST_ACK_START is a logical sub-phase only: the ack start pulses are
    // registered on entry to ST_ACK_WAIT, so the FSM never rests in it.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_SHIFT  = 3'd1,
        ST_RX_END    = 3'd2,
        ST_TX_ALIGN  = 3'd3,
        ST_TX_SHIFT  = 3'd4,
        ST_TX_END    = 3'd5,
        ST_ACK_START = 3'd6,
        ST_ACK_WAIT  = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// N-stage synchroniser for a raw bus level, plus rise/fall detection on the
// synchronised level.
module i2c_sync_edge
    import i2c_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_byte_engine.sv
// Byte-level I2C shifter: receives or transmits one byte MSB-first, then hands
// the ack clock to the external ack unit and reports completion.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  sda_in_i,
    input  logic                  start_rx_i,
    input  logic                  start_tx_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  abort_i,
    input  logic                  ack_done_i,
    input  logic                  ack_bit_i,
    output logic                  sda_out_o,
    output logic                  sda_oe_o,
    output logic                  ack_recv_start_o,
    output logic                  ack_send_start_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_nack_o,
    output logic                  byte_done_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sda_lvl;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (sclk_i),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // SDA goes through the same depth so data stays aligned with SCLK edges.
    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (sda_in_i),
        .level_o (sda_lvl),
        .rise_o  (),
        .fall_o  ()
    );

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  was_tx_q;
    logic                  sda_out_q, sda_oe_q;
    logic                  ack_recv_q, ack_send_q;
    logic                  rx_valid_q, tx_nack_q, byte_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            was_tx_q    <= 1'b0;
            sda_out_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            ack_recv_q  <= 1'b0;
            ack_send_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_nack_q   <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            byte_done_q <= 1'b0;
            ack_recv_q  <= 1'b0;
            ack_send_q  <= 1'b0;
            if (abort_i) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_rx_i) begin
                            state_q  <= ST_RX_SHIFT;
                            was_tx_q <= 1'b0;
                            cnt_q    <= '0;
                        end else if (start_tx_i) begin
                            shift_q  <= tx_data_i;
                            was_tx_q <= 1'b1;
                            cnt_q    <= '0;
                            if (sclk_lvl) begin
                                state_q <= ST_TX_ALIGN;
                            end else begin
                                state_q   <= ST_TX_SHIFT;
                                sda_oe_q  <= 1'b1;
                                sda_out_q <= tx_data_i[DATA_WIDTH-1];
                            end
                        end
                    end
                    ST_RX_SHIFT: begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[DATA_WIDTH-2:0], sda_lvl};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_FULL - CNT_W'(1)) state_q <= ST_RX_END;
                        end
                    end
                    ST_RX_END: begin
                        if (sclk_fall) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            ack_send_q <= 1'b1;
                            state_q    <= ST_ACK_WAIT;
                        end
                    end
                    ST_TX_ALIGN: begin
                        // Master is mid high-phase; join at the next low phase.
                        if (sclk_fall) begin
                            state_q   <= ST_TX_SHIFT;
                            sda_oe_q  <= 1'b1;
                            sda_out_q <= shift_q[DATA_WIDTH-1];
                        end
                    end
                    ST_TX_SHIFT: begin
                        if (sclk_rise) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end else if (sclk_fall) begin
                            if (cnt_q < CNT_FULL) begin
                                shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                                sda_out_q <= shift_q[DATA_WIDTH-2];
                            end else begin
                                state_q <= ST_TX_END;
                            end
                        end
                    end
                    ST_TX_END: begin
                        sda_oe_q   <= 1'b0;
                        ack_recv_q <= 1'b1;
                        state_q    <= ST_ACK_WAIT;
                    end
                    ST_ACK_WAIT: begin
                        if (ack_done_i) begin
                            if (was_tx_q) tx_nack_q <= ack_bit_i;
                            byte_done_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sda_out_o        = sda_out_q;
    assign sda_oe_o         = sda_oe_q;
    assign ack_recv_start_o = ack_recv_q;
    assign ack_send_start_o = ack_send_q;
    assign rx_data_o        = rx_data_q;
    assign rx_valid_o       = rx_valid_q;
    assign tx_nack_o        = tx_nack_q;
    assign byte_done_o      = byte_done_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Scoreboard bench: stimulus pushes expected bytes/bits/ack results; monitors
// pop and compare whenever the DUT presents RX_VALID, BYTE_DONE, ack starts or SCLK rises.
module tb_i2c_byte_engine;

    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, sclk = 1'b0, sda_in = 1'b1;
    logic         start_rx = 1'b0, start_tx = 1'b0, abort = 1'b0;
    logic         ack_done = 1'b0, ack_bit = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         sda_out_o, sda_oe_o, ack_recv_start_o, ack_send_start_o;
    logic [W-1:0] rx_data_o;
    logic         rx_valid_o, tx_nack_o, byte_done_o, busy_o;

    i2c_byte_engine #(.SYNC_STAGES(2), .DATA_WIDTH(W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .sclk_i           (sclk),
        .sda_in_i         (sda_in),
        .start_rx_i       (start_rx),
        .start_tx_i       (start_tx),
        .tx_data_i        (tx_data),
        .abort_i          (abort),
        .ack_done_i       (ack_done),
        .ack_bit_i        (ack_bit),
        .sda_out_o        (sda_out_o),
        .sda_oe_o         (sda_oe_o),
        .ack_recv_start_o (ack_recv_start_o),
        .ack_send_start_o (ack_send_start_o),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .tx_nack_o        (tx_nack_o),
        .byte_done_o      (byte_done_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic recv; logic bitv; } ack_t;

    int           checks = 0, errors = 0;
    int           done_cnt = 0, exp_done_total = 0;
    bit           tb_txing = 1'b0;
    logic [W-1:0] last_rx = '0;
    logic         model_nack = 1'b0;
    logic [W-1:0] exp_rx[$];
    logic         exp_nack[$];
    logic         exp_bits[$];
    ack_t         exp_ack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {sda_out_o, sda_oe_o, ack_recv_start_o, ack_send_start_o,
                rx_data_o, rx_valid_o, tx_nack_o, byte_done_o, busy_o};
    endfunction

    // RX_VALID monitor
    initial forever begin
        @(negedge clk);
        if (rx_valid_o) begin
            if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid_o, 0);
            else check("rx_data", rx_data_o, exp_rx.pop_front());
        end
    end

    // BYTE_DONE monitor
    initial forever begin
        @(negedge clk);
        if (byte_done_o) begin
            if (exp_nack.size() == 0) check("byte_done_unexpected", byte_done_o, 0);
            else begin
                check("tx_nack", tx_nack_o, exp_nack.pop_front());
                check("busy_at_done", busy_o, 0);
                done_cnt++;
            end
        end
    end

    // Bus monitor: what the DUT presents on SDA at each SCLK rise
    initial forever begin
        @(posedge sclk);
        if (tb_txing) begin
            check("tx_oe", sda_oe_o, 1);
            if (exp_bits.size() != 0) check("tx_bit", sda_out_o, exp_bits.pop_front());
        end else begin
            check("oe_not_txing", sda_oe_o, 0);
        end
    end

    // Ack-unit stand-in: checks the start pulse, answers DONE 20 cycles later
    initial begin
        logic prev_oe;
        ack_t a;
        prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_send_start_o || ack_recv_start_o) begin
                check("ack_starts_exclusive", ack_send_start_o & ack_recv_start_o, 0);
                if (ack_recv_start_o) begin
                    check("oe_low_at_ack_recv", sda_oe_o, 0);
                    check("oe_high_before_ack_recv", prev_oe, 1);
                end
                if (exp_ack.size() == 0) begin
                    check("ack_start_unexpected", {ack_send_start_o, ack_recv_start_o}, 0);
                end else begin
                    a = exp_ack.pop_front();
                    check("ack_start_kind", ack_recv_start_o, a.recv);
                    repeat (20) @(posedge clk);
                    #1;
                    ack_bit  = a.bitv;
                    ack_done = 1'b1;
                    @(posedge clk);
                    #1;
                    ack_done = 1'b0;
                    ack_bit  = 1'b0;
                end
            end
            prev_oe = sda_oe_o;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One SCLK period starting and ending low; optionally drives SDA for RX.
    task automatic sclk_bit(input int half, input bit drv, input logic b);
        if (drv) sda_in = b;
        tick(half);
        sclk = 1'b1;
        tick(half);
        sclk = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < exp_done_total && t < 4000) begin
            tick(1);
            t++;
        end
        check("byte_done_seen", done_cnt, exp_done_total);
    endtask

    task automatic rx_byte(input logic [W-1:0] b, input int half, input bit both);
        exp_rx.push_back(b);
        last_rx = b;
        exp_ack.push_back(ack_t'{1'b0, 1'b0});
        exp_nack.push_back(model_nack);
        exp_done_total++;
        start_rx = 1'b1;
        if (both) begin
            start_tx = 1'b1;
            tx_data  = 8'hFF;
        end
        tick(1);
        start_rx = 1'b0;
        start_tx = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            sclk_bit(half, 1'b1, b[i]);
            if (both && i == 4) begin
                start_tx = 1'b1;
                tick(1);
                start_tx = 1'b0;
            end
        end
        wait_done();
    endtask

    task automatic tx_byte(input logic [W-1:0] b, input int half, input logic ackb, input bit sclk_high);
        for (int i = W - 1; i >= 0; i--) exp_bits.push_back(b[i]);
        exp_ack.push_back(ack_t'{1'b1, ackb});
        exp_nack.push_back(ackb);
        model_nack = ackb;
        exp_done_total++;
        tx_data = b;
        if (sclk_high) begin
            sclk = 1'b1;
            tick(half);
        end
        start_tx = 1'b1;
        tick(1);
        start_tx = 1'b0;
        tx_data  = ~b;
        if (sclk_high) begin
            tick(10);
            check("align_oe", sda_oe_o, 0);
            check("align_busy", busy_o, 1);
            tb_txing = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
        tb_txing = 1'b1;
        for (int i = 0; i < W; i++) sclk_bit(half, 1'b0, 1'b0);
        wait_done();
        tb_txing = 1'b0;
        check("tx_bits_consumed", exp_bits.size(), 0);
    endtask

    initial begin
        logic [W-1:0] b;
        tick(3);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        tick(5);
        check("idle_outputs", all_outs(), 0);

        rx_byte(8'hA5, 20, 1'b0);
        tx_byte(8'h3C, 20, 1'b1, 1'b0);
        tx_byte(8'h81, 20, 1'b1, 1'b1);

        // Abort after four received bits
        b = 8'h3F;
        start_rx = 1'b1;
        tick(1);
        start_rx = 1'b0;
        for (int i = W - 1; i >= 4; i--) sclk_bit(20, 1'b1, b[i]);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_oe", sda_oe_o, 0);
        check("abort_rx_data_kept", rx_data_o, last_rx);
        check("abort_tx_nack_kept", tx_nack_o, model_nack);
        abort    = 1'b1;
        start_rx = 1'b1;
        tick(1);
        abort    = 1'b0;
        start_rx = 1'b0;
        check("abort_beats_start", busy_o, 0);
        tick(40);
        rx_byte(8'h12, 20, 1'b0);

        rx_byte(W'($urandom_range(0, 255)), 20, 1'b1);

        // Reset mid-transmit, after five bits
        b = W'($urandom_range(0, 255));
        for (int i = W - 1; i >= 3; i--) exp_bits.push_back(b[i]);
        tx_data  = b;
        start_tx = 1'b1;
        tick(1);
        start_tx = 1'b0;
        tb_txing = 1'b1;
        for (int i = 0; i < 5; i++) sclk_bit(20, 1'b0, 1'b0);
        tb_txing = 1'b0;
        tick(3);
        check("pre_rst_busy", busy_o, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_tx_outputs", all_outs(), 0);
        last_rx    = '0;
        model_nack = 1'b0;
        tick(10);
        tx_byte(8'h55, 20, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            b = W'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                tx_byte(b, int'($urandom_range(8, 30)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                rx_byte(b, int'($urandom_range(8, 30)), 1'b0);
            check("rx_data_held", rx_data_o, last_rx);
        end

        tick(50);
        check("queues_drained", exp_rx.size() + exp_nack.size() + exp_ack.size() + exp_bits.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
